// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, then shifts data,
// odd parity and stop on device clock edges and checks the device acknowledge.
//
// state        | meaning
// ST_IDLE      | lines released, waiting for WR_EN
// ST_INHIBIT   | ps2c held low; start bit driven in the final cycle
// ST_REQ       | clock released, start bit held, waiting for first device edge
// ST_SHIFT     | presenting data/parity/stop on device falling edges 1..10
// ST_ACK       | acknowledge sampled on edge 11, one cycle
// ST_WAIT_IDLE | waiting for device to release both lines
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       WR_EN,
  input  logic [7:0] DATA_TX,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       BUSY,
  output logic       DONE,
  output logic       ACK_ERR,
  output logic       TIMEOUT
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TO_W  = 21;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         ps2c_sync_q, ps2c_sync_d;
  logic [1:0]         ps2d_sync_q, ps2d_sync_d;
  logic [FLT_W-1:0]   flt_cnt_q, flt_cnt_d;
  logic               filt_q, filt_d;
  logic               fall_q, fall_d;
  logic [INH_W-1:0]   inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [9:0]         shift_q, shift_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic               ack_bad_q, ack_bad_d;
  logic               ps2c_oe_q, ps2c_oe_d;
  logic               ps2d_oe_q, ps2d_oe_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ack_err_q, ack_err_d;
  logic               timeout_q, timeout_d;

  logic ps2c_s;
  logic ps2d_s;
  logic timed;
  logic to_hit;

  assign ps2c_s = ps2c_sync_q[1];
  assign ps2d_s = ps2d_sync_q[1];
  assign timed  = (state_q == ST_REQ) || (state_q == ST_SHIFT) ||
                  (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE);
  assign to_hit = to_cnt_q >= TO_W'(TIMEOUT_CYCLES - 1);

  // A new clock level is accepted only after FILTER_LEN consecutive samples.
  always_comb begin
    ps2c_sync_d = {ps2c_sync_q[0], ps2c};
    ps2d_sync_d = {ps2d_sync_q[0], ps2d};
    flt_cnt_d   = '0;
    filt_d      = filt_q;
    if (ps2c_s != filt_q) begin
      if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
        filt_d = ps2c_s;
      end else begin
        flt_cnt_d = flt_cnt_q + FLT_W'(1);
      end
    end
    fall_d = filt_q & ~filt_d;
  end

  always_comb begin
    state_d   = state_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    ack_bad_d = ack_bad_q;
    ps2c_oe_d = ps2c_oe_q;
    ps2d_oe_d = ps2d_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = 1'b0;
    timeout_d = 1'b0;

    if (timed && (to_cnt_q != '1)) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (WR_EN) begin
          state_d   = ST_INHIBIT;
          busy_d    = 1'b1;
          ps2c_oe_d = 1'b1;
          ps2d_oe_d = 1'b0;
          shift_d   = {1'b1, ~^DATA_TX, DATA_TX};
          bit_cnt_d = '0;
          to_cnt_d  = '0;
          ack_bad_d = 1'b0;
          inh_cnt_d = INH_W'(INHIBIT_CYCLES - 1);
        end
      end
      ST_INHIBIT: begin
        if (inh_cnt_q == '0) begin
          ps2c_oe_d = 1'b0;
          state_d   = ST_REQ;
        end else begin
          inh_cnt_d = inh_cnt_q - INH_W'(1);
          if (inh_cnt_q == INH_W'(1)) begin
            ps2d_oe_d = 1'b1;
          end
        end
      end
      ST_REQ, ST_SHIFT: begin
        if (fall_q) begin
          if (bit_cnt_q == 4'd10) begin
            ack_bad_d = ps2d_s;
            ps2d_oe_d = 1'b0;
            state_d   = ST_ACK;
          end else begin
            ps2d_oe_d = ~shift_q[0];
            shift_d   = {1'b1, shift_q[9:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
            state_d   = ST_SHIFT;
          end
        end
      end
      ST_ACK: begin
        state_d = ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (filt_q && ps2d_s) begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          ack_err_d = ack_bad_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over a simultaneous normal completion so the flags stay exclusive.
    if (timed && to_hit) begin
      state_d   = ST_IDLE;
      ps2c_oe_d = 1'b0;
      ps2d_oe_d = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b1;
      timeout_d = 1'b1;
      ack_err_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      ps2c_sync_q <= 2'b11;
      ps2d_sync_q <= 2'b11;
      flt_cnt_q   <= '0;
      filt_q      <= 1'b1;
      fall_q      <= 1'b0;
      inh_cnt_q   <= '0;
      to_cnt_q    <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      ack_bad_q   <= 1'b0;
      ps2c_oe_q   <= 1'b0;
      ps2d_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ps2c_sync_q <= ps2c_sync_d;
      ps2d_sync_q <= ps2d_sync_d;
      flt_cnt_q   <= flt_cnt_d;
      filt_q      <= filt_d;
      fall_q      <= fall_d;
      inh_cnt_q   <= inh_cnt_d;
      to_cnt_q    <= to_cnt_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      ack_bad_q   <= ack_bad_d;
      ps2c_oe_q   <= ps2c_oe_d;
      ps2d_oe_q   <= ps2d_oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ack_err_q   <= ack_err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign ps2c_oe = ps2c_oe_q;
  assign ps2d_oe = ps2d_oe_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign ACK_ERR = ack_err_q;
  assign TIMEOUT = timeout_q;

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the controller to the keyboard over the open-drain ps2c/ps2d lines. It is the transmit counterpart of the existing PS/2 keyboard receiver and shares the same physical lines. It generates the inhibit/request-to-send sequence, shifts data, parity and stop bits on device-generated clock edges, checks the device acknowledge, and reports completion or error to the control logic.

## Interface
Parameters:
- INHIBIT_CYCLES, 10000 — CLK cycles ps2c is held low before the request (100 µs at 100 MHz).
- TIMEOUT_CYCLES, 1500000 — maximum CLK cycles from clock release to acknowledge before abort (15 ms).
- FILTER_LEN, 8 — consecutive identical samples required to accept a new ps2c level.

Ports:
- CLK  in  1  system clock (only clock domain).
- RST  in  1  asynchronous, active-high reset.
- WR_EN  in  1  start request; sampled when BUSY=0.
- DATA_TX  in  8  byte to send; latched on an accepted WR_EN.
- ps2c  in  1  PS/2 clock line level (asynchronous).
- ps2d  in  1  PS/2 data line level (asynchronous).
- ps2c_oe  out  1  1 = drive ps2c low, 0 = release (high-Z).
- ps2d_oe  out  1  1 = drive ps2d low, 0 = release.
- BUSY  out  1  transfer in progress.
- DONE  out  1  one-cycle pulse at end of every accepted transfer.
- ACK_ERR  out  1  valid with DONE: device did not pull ps2d low on the 11th clock.
- TIMEOUT  out  1  valid with DONE: transfer aborted by the timeout counter.

## Operation
- ps2c and ps2d pass through 2-FF synchronizers; synchronized ps2c passes through a FILTER_LEN-sample glitch filter (filtered level, reset 1). A falling edge is filtered 1→0.
- On accept: shift register loads {stop=1, parity=~^DATA_TX (odd), DATA_TX}; bit counter cleared; timeout counter cleared.
- States:
  - IDLE: both oe=0, BUSY=0. WR_EN → INHIBIT.
  - INHIBIT: ps2c_oe=1 for INHIBIT_CYCLES cycles; ps2d_oe=1 (start bit) asserted in the last inhibit cycle → REQ.
  - REQ: ps2c_oe=0, ps2d_oe=1; timeout counter runs. Each filtered falling edge: ps2d_oe ← ~shift[0], shift right, counter+1 → SHIFT.
  - SHIFT: the same per-edge action; falling edges 1–8 present data LSB first, edge 9 parity, edge 10 stop (ps2d_oe=0). Edge 11 → ACK.
  - ACK: on the edge-11 cycle, sample synchronized ps2d; 0 = ack OK, 1 = ACK_ERR. Then → WAIT_IDLE.
  - WAIT_IDLE: both oe=0; wait until filtered ps2c=1 and synchronized ps2d=1 → IDLE with DONE pulse.
- Timeout: counter reaching TIMEOUT_CYCLES in REQ/SHIFT/ACK/WAIT_IDLE → release both lines, → IDLE, DONE=1, TIMEOUT=1, ACK_ERR=0.
- ACK_ERR and TIMEOUT are mutually exclusive and 0 whenever DONE=0.
- WR_EN while BUSY=1 is ignored (no queueing). DATA_TX changes after acceptance have no effect.

## Timing
- Reset values: ps2c_oe=0, ps2d_oe=0, BUSY=0, DONE=0, ACK_ERR=0, TIMEOUT=0, state IDLE, filtered clock=1. RST mid-transfer releases both lines immediately (asynchronously); no DONE is generated.
- WR_EN high at edge k → BUSY=1 and ps2c_oe=1 from k+1; ps2c_oe high for exactly INHIBIT_CYCLES cycles.
- Falling-edge detect latency: 2 (sync) + FILTER_LEN cycles after the pin transition; ps2d_oe updates on the cycle after detection.
- DONE, ACK_ERR and TIMEOUT are high for exactly one cycle; BUSY falls in the same cycle DONE rises.
- WR_EN asserted during the DONE cycle is accepted (BUSY=0 then) and starts a new INHIBIT the next cycle.
- The timeout counter is 21 bits wide and saturates; it never wraps.

## Test plan
Use INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000, FILTER_LEN=4; the device model clocks at 40 CLK per half period.
- Send 0xED with device ack → ps2d_oe bits on edges 1–10 = ~{1,0,1,1,0,1,1,1,parity 1,stop 1}; DONE=1, ACK_ERR=0, TIMEOUT=0.
- Send 0x01 with device ack → parity bit 0 (ps2d_oe=1 on edge 9); 0xFF → parity 1; 0x00 → parity 1.
- Send 0xF4 with the model not pulling ps2d low on edge 11 → DONE with ACK_ERR=1.
- Send 0xFF with the model never generating a clock → ps2c_oe high for 20 cycles, then after 2000 cycles both oe=0, DONE=1, TIMEOUT=1.
- Inject 2-cycle low glitches on ps2c during SHIFT → no extra bits are shifted, and the byte arrives intact.
- Assert RST after edge 5 → both oe=0 immediately, BUSY=0, no DONE; next WR_EN with 0xED completes normally. WR_EN pulses while BUSY=1 are ignored.
